alu_reservation_station: RTL
============================

Name: alu_reservation_station

Overview:
- Buffers ALU instructions from the dispatch stage until both source operands are available, then issues them to the combinational FU_ALU.
- Instantiates one FU_ALU internally and registers its result into an output stage that drives the common data bus (CDB) request.
- Operand wakeup comes from snooping the CDB.
- One instance sits in front of each ALU.

Parameters:
- NUM_ENTRIES, 4, number of station entries (power of two, 2..8).
- TAG_W, 4, width of rename/destination tags.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all entries and the output stage.
- disp_valid  in  1  dispatch offers an instruction.
- disp_ready  out  1  station has a free entry.
- disp_op  in  3  operation code (operationList: addop, subop, andop, xorop, sraop).
- disp_dst_tag  in  TAG_W  destination tag.
- disp_src1_rdy  in  1  src1 value valid.
- disp_src1_val  in  32  src1 value.
- disp_src1_tag  in  TAG_W  src1 producer tag.
- disp_src2_rdy  in  1  src2 value valid.
- disp_src2_val  in  32  src2 value.
- disp_src2_tag  in  TAG_W  src2 producer tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB broadcast tag.
- cdb_value  in  32  CDB broadcast value.
- res_valid  out  1  result waiting for CDB grant.
- res_tag  out  TAG_W  result destination tag.
- res_value  out  32  ALU result.
- res_grant  in  1  CDB arbiter accepts result this cycle.
- occupancy  out  $clog2(NUM_ENTRIES+1)  number of valid entries.

Behaviour:
- Reset (async, immediate):
  - All entries invalid.
  - res_valid=0, res_tag=0, res_value=0, occupancy=0.
  - disp_ready=1 once rst deasserts.
- disp_ready: asserted when at least one entry is free, computed from registered state only. An entry freed by issue this cycle is not reusable until the next cycle.
- Allocation: on disp_valid&&disp_ready at a rising edge, the instruction is written into the lowest-index free entry. Each entry stores op, dst tag, per-source rdy/val/tag, and a dispatch-order age.
- Wakeup: every edge with cdb_valid=1, each valid entry's source with rdy=0 and tag==cdb_tag captures cdb_value and sets rdy=1. Both sources of one entry may wake on the same broadcast.
- Dispatch bypass: if a dispatched source has rdy=0 and cdb_valid with a matching cdb_tag in the same cycle, the entry is written with rdy=1 and val=cdb_value.
- Select:
  - Candidates are valid entries with both sources ready.
  - The oldest candidate (earliest accepted) issues when the output stage is free or draining, i.e. !res_valid || res_grant.
  - At most one issue per cycle.
- Issue (at the edge): the entry is freed; res_value <= FU_ALU(op, src1, src2); res_tag <= dst tag; res_valid <= 1.
- ALU arithmetic:
  - 32-bit, modulo 2^32.
  - sraop shifts arithmetically by src2[4:0].
  - Undefined op codes produce 0 and still complete with their tag.
- Output hold: while res_valid && !res_grant, res_tag and res_value stay stable and nothing issues.
- Output drain: res_grant with no issuing candidate clears res_valid at the edge. res_grant while res_valid=0 is ignored.
- Latency: with both sources ready at dispatch and the output stage free, an instruction accepted at edge E0 issues at E1, so res_valid is high in the cycle after E1. Minimum dispatch-to-result is 2 cycles.
- Wakeup-to-issue: an entry woken at edge Ew issues no earlier than Ew+1.
- Full: occupancy==NUM_ENTRIES gives disp_ready=0. Dispatch is held off with no loss or overwrite.
- Flush:
  - Takes priority over dispatch, wakeup, issue and grant in the same cycle.
  - At the next edge all entries are invalid, res_valid=0 and occupancy=0; res_tag and res_value are don't-care.
- Reset mid-operation: same end state as reset, applied immediately without waiting for a clock edge.
- occupancy: registered count of valid entries. It reflects allocation and issue of the same edge; simultaneous allocate and issue leave it unchanged.

Test Plan:
- Reset; dispatch addop 5+7, dst 3, both ready, res_grant=1 -> res_valid high 2 cycles after accept with tag 3, value 12; occupancy returns to 0.
- Dispatch subop src1=10 ready, src2 waiting on tag 9; CDB tag 9 value 2 three cycles later -> no result before wakeup; result 8 with its dst tag exactly 2 cycles after the broadcast edge.
- Dispatch 4 instructions all waiting on tag 5 -> disp_ready=0 and a 5th is held. CDB tag 5 value 1 -> results issue one per cycle in dispatch order; disp_ready=1 after the first issue.
- Hold res_grant=0 for 3 cycles with 2 ready entries -> res_tag/res_value stable and occupancy stays 2. Grant -> the next result appears on the following cycle.
- Dispatch sraop with src1 ready 0x80000000, src2 waiting on tag 2, while CDB broadcasts tag 2 value 4 in the same cycle -> bypass captured; result 0xF8000000.
- With 3 entries valid and res_valid=1, assert flush together with disp_valid -> next cycle occupancy=0, res_valid=0, dispatch dropped. Repeat using async rst mid-cycle -> outputs clear without a clock edge.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops until both operands are
// ready, issues the oldest ready op to the ALU and holds the result for the CDB.

module fu_alu #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]               op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);
  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    case (op)
      3'd0:    y = a + b;
      3'd1:    y = a - b;
      3'd2:    y = a & b;
      3'd3:    y = a ^ b;
      3'd4:    y = a >>> b[SH_W-1:0];
      default: y = '0;
    endcase
  end
endmodule

module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [2:0]                         disp_op,
  input  logic [TAG_W-1:0]                   disp_dst_tag,
  input  logic                               disp_src1_rdy,
  input  logic [31:0]                        disp_src1_val,
  input  logic [TAG_W-1:0]                   disp_src1_tag,
  input  logic                               disp_src2_rdy,
  input  logic [31:0]                        disp_src2_val,
  input  logic [TAG_W-1:0]                   disp_src2_tag,
  input  logic                               cdb_valid,
  input  logic [TAG_W-1:0]                   cdb_tag,
  input  logic [31:0]                        cdb_value,
  output logic                               res_valid,
  output logic [TAG_W-1:0]                   res_tag,
  output logic [31:0]                        res_value,
  input  logic                               res_grant,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int OCC_W  = $clog2(NUM_ENTRIES+1);

  logic [NUM_ENTRIES-1:0]   ent_vld;
  logic [NUM_ENTRIES-1:0]   s1_rdy;
  logic [NUM_ENTRIES-1:0]   s2_rdy;
  logic [IDX_W-1:0]         ent_age [NUM_ENTRIES];
  logic [2:0]               ent_op  [NUM_ENTRIES];
  logic [TAG_W-1:0]         ent_dst [NUM_ENTRIES];
  logic [TAG_W-1:0]         s1_tag  [NUM_ENTRIES];
  logic [TAG_W-1:0]         s2_tag  [NUM_ENTRIES];
  logic signed [DATA_W-1:0] s1_val  [NUM_ENTRIES];
  logic signed [DATA_W-1:0] s2_val  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]   cand_p0;
  logic [NUM_ENTRIES-1:0]   wake1;
  logic [NUM_ENTRIES-1:0]   wake2;
  logic                     sel_found_p0;
  logic [IDX_W-1:0]         sel_idx_p0;
  logic                     issue_p0;
  logic                     alloc_found;
  logic [IDX_W-1:0]         alloc_idx;
  logic                     alloc;
  logic                     byp1;
  logic                     byp2;
  logic [OCC_W-1:0]         occ_remain;
  logic [IDX_W-1:0]         new_age;
  logic signed [DATA_W-1:0] alu_y_p0;

  // Oldest-ready select and lowest-free allocation, both from registered state
  always_comb begin
    cand_p0      = ent_vld & s1_rdy & s2_rdy;
    sel_found_p0 = 1'b0;
    sel_idx_p0   = '0;
    alloc_found  = 1'b0;
    alloc_idx    = '0;
    wake1        = '0;
    wake2        = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cand_p0[i] && (!sel_found_p0 || ent_age[i] < ent_age[sel_idx_p0])) begin
        sel_found_p0 = 1'b1;
        sel_idx_p0   = IDX_W'(i);
      end
      if (!ent_vld[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      wake1[i] = cdb_valid && ent_vld[i] && !s1_rdy[i] && (s1_tag[i] == cdb_tag);
      wake2[i] = cdb_valid && ent_vld[i] && !s2_rdy[i] && (s2_tag[i] == cdb_tag);
    end
  end

  assign disp_ready = alloc_found;
  assign alloc      = disp_valid && alloc_found;
  assign issue_p0   = sel_found_p0 && (!res_valid || res_grant);
  assign byp1       = !disp_src1_rdy && cdb_valid && (disp_src1_tag == cdb_tag);
  assign byp2       = !disp_src2_rdy && cdb_valid && (disp_src2_tag == cdb_tag);
  // A new entry is younger than every entry that survives this edge
  assign occ_remain = occupancy - OCC_W'(issue_p0);
  assign new_age    = IDX_W'(occ_remain);

  fu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (ent_op[sel_idx_p0]),
    .a  (s1_val[sel_idx_p0]),
    .b  (s2_val[sel_idx_p0]),
    .y  (alu_y_p0)
  );

  // ---- stage boundary: entry control and output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld   <= '0;
      s1_rdy    <= '0;
      s2_rdy    <= '0;
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_value <= '0;
      occupancy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) ent_age[i] <= '0;
    end else if (flush) begin
      ent_vld   <= '0;
      res_valid <= 1'b0;
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(alloc) - OCC_W'(issue_p0);
      if (issue_p0) begin
        res_valid <= 1'b1;
        res_tag   <= ent_dst[sel_idx_p0];
        res_value <= alu_y_p0;
      end else if (res_grant) begin
        res_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_p0 && sel_idx_p0 == IDX_W'(i))
          ent_vld[i] <= 1'b0;
        else if (issue_p0 && ent_vld[i] && ent_age[i] > ent_age[sel_idx_p0])
          ent_age[i] <= ent_age[i] - IDX_W'(1);
        if (wake1[i]) s1_rdy[i] <= 1'b1;
        if (wake2[i]) s2_rdy[i] <= 1'b1;
        if (alloc && alloc_idx == IDX_W'(i)) begin
          ent_vld[i] <= 1'b1;
          ent_age[i] <= new_age;
          s1_rdy[i]  <= disp_src1_rdy || byp1;
          s2_rdy[i]  <= disp_src2_rdy || byp2;
        end
      end
    end
  end

  // ---- stage boundary: entry payload (no reset, qualified by control) ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc && alloc_idx == IDX_W'(i)) begin
        ent_op[i]  <= disp_op;
        ent_dst[i] <= disp_dst_tag;
        s1_tag[i]  <= disp_src1_tag;
        s2_tag[i]  <= disp_src2_tag;
        s1_val[i]  <= disp_src1_rdy ? disp_src1_val : cdb_value;
        s2_val[i]  <= disp_src2_rdy ? disp_src2_val : cdb_value;
      end else begin
        if (wake1[i]) s1_val[i] <= cdb_value;
        if (wake2[i]) s2_val[i] <= cdb_value;
      end
    end
  end
endmodule
